trig_window_checker: RTL and testbench

Synthesizable, clocked replacement for our ad-hoc "on a, wait for d, then check b||c" immediate-assertion checkers.
- Arms on trigger `a`.
- Waits a bounded number of cycles for a rising edge on qualifier `d`.
- At that edge, checks that `b || c` holds.
- Reports pass, fail or timeout as single-cycle pulses and in saturating counters.
- Sits beside the datapath under test in the tb and optionally in silicon as a debug monitor; counters are read by the tb or the debug bus.

---
 rtl/chk_pkg.sv | 25 ++
 rtl/sat_cnt.sv | 32 +++
 rtl/trig_window_checker.sv | 161 ++++++++++++++++
 tb/tb_trig_window_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
// -----------------------------------------------------------------------------
// chk_pkg
// Shared types and defaults for the trigger/window checker.
//   chk_state_e : checker FSM states (IDLE, ARMED)
//   res_e       : outcome of one checked window (pass, fail, timeout)
//   CHK_TIMEOUT_CYC_DEF / CHK_CNT_W_DEF : default parameter values
// No ports.
// -----------------------------------------------------------------------------
package chk_pkg;

  localparam int CHK_TIMEOUT_CYC_DEF = 16;
  localparam int CHK_CNT_W_DEF       = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } chk_state_e;

  typedef enum logic [1:0] {
    RES_PASS    = 2'd0,
    RES_FAIL    = 2'd1,
    RES_TIMEOUT = 2'd2
  } res_e;

endpackage

// File: rtl/sat_cnt.sv
// -----------------------------------------------------------------------------
// sat_cnt
// Saturating event counter with synchronous clear. Clear has priority over
// increment; the count holds at all-ones once reached.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low reset (count -> 0)
//   inc   in   count one event this edge
//   clr   in   synchronous clear
//   q     out  [W-1:0] current count
// -----------------------------------------------------------------------------
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/trig_window_checker.sv
// -----------------------------------------------------------------------------
// trig_window_checker
// Clocked "on a, wait for a rising d, then check b||c" monitor.
// Arms on trigger a, waits up to TIMEOUT_CYC edges for a fresh 0->1 on d,
// then reports pass/fail (b||c at that edge) or timeout as one-cycle pulses
// and in saturating counters.
//
// Optional build macro CHK_MSG_EN: when defined, a simulation-only block
// prints a message for every pass/fail/timeout event. Hardware and ports are
// identical with or without it.
//
// Parameters:
//   TIMEOUT_CYC  edges spent ARMED without a d rise before timeout (>=1)
//   CNT_W        width of each event counter
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   en             in   enable; low aborts/blocks any window
//   a              in   trigger
//   d              in   qualifier, rising edge detected synchronously
//   b, c           in   check operands
//   clr            in   synchronous clear of all counters
//   busy           out  high while ARMED
//   pass_pulse     out  one-cycle pulse, check passed
//   fail_pulse     out  one-cycle pulse, check failed
//   timeout_pulse  out  one-cycle pulse, window expired
//   pass_cnt       out  [CNT_W-1:0] saturating pass count
//   fail_cnt       out  [CNT_W-1:0] saturating fail count
//   timeout_cnt    out  [CNT_W-1:0] saturating timeout count
// -----------------------------------------------------------------------------
module trig_window_checker
  import chk_pkg::*;
#(
  parameter int TIMEOUT_CYC = CHK_TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CHK_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             d,
  input  logic             b,
  input  logic             c,
  input  logic             clr,
  output logic             busy,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic             timeout_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  // A single-edge window still needs a 1-bit counter to compare against 0.
  localparam int                WAIT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  chk_state_e        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              d_q;
  logic              d_rise;
  logic              pass_nxt, fail_nxt, timeout_nxt;

  // d_q tracks d every cycle regardless of state, so a d that is already
  // high when the checker arms never produces a rise.
  assign d_rise = d & ~d_q;
  assign busy   = (state == ARMED);

  // Decision logic: abort > d rise > window expiry > keep waiting.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    pass_nxt    = 1'b0;
    fail_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (en && a) begin
          state_nxt = ARMED;
          wait_nxt  = '0;
        end
      end
      ARMED: begin
        if (!en) begin
          state_nxt = IDLE;
          wait_nxt  = '0;
        end else if (d_rise) begin
          state_nxt = IDLE;
          wait_nxt  = '0;
          pass_nxt  = b | c;
          fail_nxt  = ~(b | c);
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = IDLE;
          wait_nxt    = '0;
          timeout_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        wait_nxt  = '0;
      end
    endcase
  end

  // ---- registered stage: FSM state, edge history, event pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      d_q           <= 1'b0;
      pass_pulse    <= 1'b0;
      fail_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_nxt;
      d_q           <= d;
      pass_pulse    <= pass_nxt;
      fail_pulse    <= fail_nxt;
      timeout_pulse <= timeout_nxt;
    end
  end

  // Counters advance on the same edge that registers the matching pulse.
  sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pass_nxt),
    .clr   (clr),
    .q     (pass_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_nxt),
    .clr   (clr),
    .q     (fail_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (timeout_nxt),
    .clr   (clr),
    .q     (timeout_cnt)
  );

`ifdef CHK_MSG_EN
  always @(posedge clk) begin
    if (pass_pulse)    $display("%0d %m: check passed", $stime);
    if (fail_pulse)    $warning("%0d %m: check failed", $stime);
    if (timeout_pulse) $warning("%0d %m: timeout", $stime);
  end
`else
  // Messaging disabled: no simulation output from this block.
`endif

endmodule

// File: tb/tb_trig_window_checker.sv
// -----------------------------------------------------------------------------
// tb_trig_window_checker
// Directed scenarios followed by a random phase. A window-based reference
// model (remaining edges in the current window, previous d, three counts)
// predicts every output after every edge.
// -----------------------------------------------------------------------------
module tb_trig_window_checker;
  import chk_pkg::*;

  localparam int TO   = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          a     = 1'b0;
  logic          d     = 1'b0;
  logic          b     = 1'b0;
  logic          c     = 1'b0;
  logic          clr   = 1'b0;
  logic          busy, pass_pulse, fail_pulse, timeout_pulse;
  logic [CW-1:0] pass_cnt, fail_cnt, timeout_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state.
  int   m_left  = 0;       // edges still allowed in the open window, 0 = none
  logic m_dprev = 1'b0;
  bit   m_evt   = 1'b0;
  res_e m_res   = RES_PASS;
  int   m_cnt[3] = '{0, 0, 0};

  trig_window_checker #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .a             (a),
    .d             (d),
    .b             (b),
    .c             (c),
    .clr           (clr),
    .busy          (busy),
    .pass_pulse    (pass_pulse),
    .fail_pulse    (fail_pulse),
    .timeout_pulse (timeout_pulse),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":busy"},    {31'd0, busy},          {31'd0, m_left > 0});
    chk({tag, ":pass"},    {31'd0, pass_pulse},    {31'd0, m_evt && m_res == RES_PASS});
    chk({tag, ":fail"},    {31'd0, fail_pulse},    {31'd0, m_evt && m_res == RES_FAIL});
    chk({tag, ":timeout"}, {31'd0, timeout_pulse}, {31'd0, m_evt && m_res == RES_TIMEOUT});
    chk({tag, ":pass_cnt"},    {30'd0, pass_cnt},    m_cnt[0]);
    chk({tag, ":fail_cnt"},    {30'd0, fail_cnt},    m_cnt[1]);
    chk({tag, ":timeout_cnt"}, {30'd0, timeout_cnt}, m_cnt[2]);
  endtask

  // Predict the outcome of the coming edge from the inputs now applied.
  task automatic model_edge();
    bit rise;
    rise  = d && !m_dprev;
    m_evt = 1'b0;
    if (m_left > 0) begin
      if (!en) begin
        m_left = 0;
      end else if (rise) begin
        m_evt  = 1'b1;
        m_res  = (b || c) ? RES_PASS : RES_FAIL;
        m_left = 0;
      end else if (m_left == 1) begin
        m_evt  = 1'b1;
        m_res  = RES_TIMEOUT;
        m_left = 0;
      end else begin
        m_left--;
      end
    end else if (en && a) begin
      m_left = TO;
    end
    m_dprev = d;
    if (clr) m_cnt = '{0, 0, 0};
    else if (m_evt && m_cnt[int'(m_res)] < CMAX) m_cnt[int'(m_res)]++;
  endtask

  task automatic model_reset();
    m_left  = 0;
    m_dprev = 1'b0;
    m_evt   = 1'b0;
    m_cnt   = '{0, 0, 0};
  endtask

  // Apply inputs, advance one edge, check everything 1 time unit later.
  task automatic cyc(input logic i_en, input logic i_a, input logic i_d,
                     input logic i_b, input logic i_c, input logic i_clr,
                     input string tag);
    en = i_en; a = i_a; d = i_d; b = i_b; c = i_c; clr = i_clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state.
    #3;
    check_all("reset");
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #4;  // now at posedge-1; next cyc edge is edge 1

    // 1: arm at edge 1, d rises at edge 3 with b=c=0 -> fail.
    cyc(1, 1, 0, 0, 0, 0, "t1_e1");
    chk("t1_busy_armed", {31'd0, busy}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, "t1_e2");
    cyc(1, 0, 1, 0, 0, 0, "t1_e3");
    chk("t1_fail_pulse", {31'd0, fail_pulse}, 32'd1);
    chk("t1_fail_cnt",   {30'd0, fail_cnt},   32'd1);
    chk("t1_pass_cnt",   {30'd0, pass_cnt},   32'd0);
    chk("t1_busy_low",   {31'd0, busy},       32'd0);
    cyc(1, 0, 1, 0, 0, 0, "t1_e4");
    chk("t1_pulse_single", {31'd0, fail_pulse}, 32'd0);

    // 2: pass with b=1, then back-to-back arm on the next edge.
    cyc(1, 0, 0, 0, 0, 1, "t2_clr");
    cyc(1, 1, 0, 0, 0, 0, "t2_arm");
    cyc(1, 0, 0, 0, 0, 0, "t2_wait");
    cyc(1, 0, 1, 1, 0, 0, "t2_rise");
    chk("t2_pass_pulse", {31'd0, pass_pulse}, 32'd1);
    chk("t2_pass_cnt1",  {30'd0, pass_cnt},   32'd1);
    cyc(1, 1, 0, 0, 0, 0, "t2_rearm");
    chk("t2_rearm_busy", {31'd0, busy}, 32'd1);
    cyc(1, 0, 1, 1, 0, 0, "t2_rise2");
    chk("t2_pass_cnt2",  {30'd0, pass_cnt}, 32'd2);

    // 3: timeout after the 16th ARMED edge; variant with d rise on that edge.
    cyc(1, 0, 0, 0, 0, 1, "t3_clr");
    cyc(1, 1, 0, 0, 0, 0, "t3_arm");
    for (int i = 1; i < TO; i++) cyc(1, 0, 0, 0, 0, 0, "t3_wait");
    chk("t3_busy_before", {31'd0, busy}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, "t3_expire");
    chk("t3_timeout_pulse", {31'd0, timeout_pulse}, 32'd1);
    chk("t3_timeout_cnt",   {30'd0, timeout_cnt},   32'd1);
    cyc(1, 1, 0, 0, 0, 0, "t3b_arm");
    for (int i = 1; i < TO; i++) cyc(1, 0, 0, 0, 0, 0, "t3b_wait");
    cyc(1, 0, 1, 0, 1, 0, "t3b_rise_at_expiry");
    chk("t3b_pass_wins", {31'd0, pass_pulse},    32'd1);
    chk("t3b_no_timeout", {31'd0, timeout_pulse}, 32'd0);

    // 4: d already high when arming -> only timeout; then a fresh rise counts.
    cyc(1, 0, 1, 0, 0, 1, "t4_clr");
    cyc(1, 1, 1, 0, 0, 0, "t4_arm_dhigh");
    for (int i = 0; i < TO; i++) cyc(1, 0, 1, 0, 0, 0, "t4_hold");
    chk("t4_timeout", {31'd0, timeout_pulse}, 32'd1);
    chk("t4_no_fail", {30'd0, fail_cnt},      32'd0);
    chk("t4_no_pass", {30'd0, pass_cnt},      32'd0);
    cyc(1, 1, 1, 0, 0, 0, "t4_arm2");
    cyc(1, 0, 0, 0, 0, 0, "t4_dlow");
    cyc(1, 0, 1, 0, 0, 0, "t4_rise");
    chk("t4_fail_eval", {31'd0, fail_pulse}, 32'd1);

    // 5: fail counter saturates at 3; clr beats the increment of a 6th fail.
    cyc(1, 0, 0, 0, 0, 1, "t5_clr");
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0, 0, 0, 0, "t5_arm");
      cyc(1, 0, 1, 0, 0, 0, "t5_rise");
    end
    chk("t5_saturated", {30'd0, fail_cnt}, 32'd3);
    cyc(1, 1, 0, 0, 0, 0, "t5_arm6");
    cyc(1, 0, 1, 0, 0, 1, "t5_rise_clr");
    chk("t5_pulse_with_clr", {31'd0, fail_pulse}, 32'd1);
    chk("t5_clr_wins",       {30'd0, fail_cnt},   32'd0);

    // 6: abort by en, extra a ignored, async reset mid-window.
    cyc(1, 1, 0, 0, 0, 0, "t6_arm");
    cyc(1, 0, 0, 0, 0, 0, "t6_wait");
    cyc(0, 0, 1, 1, 1, 0, "t6_abort");
    chk("t6_abort_idle", {31'd0, busy}, 32'd0);
    chk("t6_abort_nopass", {31'd0, pass_pulse}, 32'd0);
    cyc(1, 1, 0, 0, 0, 0, "t6_arm2");
    for (int i = 1; i < TO; i++) cyc(1, (i == 5), 0, 0, 0, 0, "t6_rea");
    cyc(1, 0, 0, 0, 0, 0, "t6_expire");
    chk("t6_no_extend", {31'd0, timeout_pulse}, 32'd1);
    cyc(1, 1, 0, 0, 0, 0, "t6_arm3");
    cyc(1, 0, 0, 0, 0, 0, "t6_wait3");
    mid_reset("t6_reset");
    chk("t6_reset_busy", {31'd0, busy}, 32'd0);
    chk("t6_reset_cnt",  {30'd0, timeout_cnt}, 32'd0);
    cyc(1, 0, 1, 1, 0, 0, "t6_after_reset");
    chk("t6_no_pulse_after_reset", {31'd0, pass_pulse}, 32'd0);

    // Random phase.
    for (int i = 0; i < 1200; i++) begin
      int flip_rate;
      logic nd;
      flip_rate = ((i / 150) % 2 == 1) ? 24 : 4;
      nd = ($urandom_range(0, flip_rate - 1) == 0) ? ~d : d;
      cyc(($urandom_range(0, 15) != 0),
          ($urandom_range(0, 5) == 0),
          nd,
          logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 1)),
          ($urandom_range(0, 39) == 0),
          "rand");
      if ($urandom_range(0, 199) == 0) mid_reset("rand_reset");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
